// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin front end that time-shares one external
// combinational W x W multiplier between NUM_REQ valid/ready requesters.
// One operation in flight; operands are registered toward the multiplier and
// the product is captured after SETTLE cycles into a tagged response register.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 4,
    parameter int ID_W    = 2,
    parameter int SETTLE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2*W-1:0]       rsp_p,
    output logic                 busy,
    output logic [7:0]           done_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]                  state;
    logic [3:0]                  settle_cnt;
    logic [ID_W-1:0]             rr_ptr;
    logic [ID_W-1:0]             cur_id;
    logic [ID_W-1:0]             gnt_id;
    logic                        gnt_any;
    logic                        accept;
    logic [NUM_REQ-1:0][W-1:0]   a_lane;
    logic [NUM_REQ-1:0][W-1:0]   b_lane;

    // Unpack the flattened operand buses into per-lane views.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign a_lane[i] = req_a[i*W +: W];
        assign b_lane[i] = req_b[i*W +: W];
    end

    // Round-robin search: first valid lane at or after rr_ptr, with wrap.
    always_comb begin
        logic [ID_W-1:0] idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    // One-hot grant, only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == S_IDLE) && gnt_any)
            req_ready[gnt_id] = 1'b1;
    end

    assign accept = |(req_ready & req_valid);
    assign busy   = (state != S_IDLE);

    // Control path: accept -> hold operands SETTLE cycles -> present response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            rr_ptr     <= '0;
            cur_id     <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_p      <= '0;
            done_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mul_a      <= a_lane[gnt_id];
                        mul_b      <= b_lane[gnt_id];
                        cur_id     <= gnt_id;
                        settle_cnt <= 4'(SETTLE - 1);
                        state      <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        rsp_p     <= mul_p;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + 8'd1;
                        // Next search starts just past the lane just served.
                        rr_ptr    <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                    : cur_id + ID_W'(1);
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed vector table, hand-written corner
// sequences (arbitration, backpressure, reset mid-op, SETTLE=3) and a
// randomized run against a transaction-level reference model.
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // SETTLE=1 instance signals
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic           rsp_valid, rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [2*W-1:0] rsp_p;
    logic           busy;
    logic [7:0]     done_cnt;

    // SETTLE=3 instance signals
    logic [N-1:0]   req_valid3;
    logic [N*W-1:0] req_a3, req_b3;
    logic [N-1:0]   req_ready3;
    logic [W-1:0]   mul_a3, mul_b3;
    logic [2*W-1:0] mul_p3;
    logic           rsp_valid3, rsp_ready3;
    logic [IDW-1:0] rsp_id3;
    logic [2*W-1:0] rsp_p3;
    logic           busy3;
    logic [7:0]     done_cnt3;

    mult_share_arbiter #(.NUM_REQ(N), .W(W), .ID_W(IDW), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .busy(busy), .done_cnt(done_cnt)
    );

    mult_share_arbiter #(.NUM_REQ(N), .W(W), .ID_W(IDW), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
        .req_ready(req_ready3), .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_p(rsp_p3),
        .busy(busy3), .done_cnt(done_cnt3)
    );

    // Ideal multiplier for the SETTLE=1 instance.
    assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

    // Slow multiplier for the SETTLE=3 instance: output is junk until the
    // operands have been stable across two edges, so an early sample shows.
    logic [W-1:0] pa3, pb3;
    int           st3 = 0;
    always @(negedge clk) begin
        if (mul_a3 !== pa3 || mul_b3 !== pb3) begin
            st3 <= 0;
            pa3 <= mul_a3;
            pb3 <= mul_b3;
        end else begin
            st3 <= st3 + 1;
        end
    end
    assign mul_p3 = (st3 >= 2) ? {4'b0, mul_a3} * {4'b0, mul_b3} : 8'hEE;

    int errors = 0;
    int checks = 0;
    int got_id[$];
    int got_p[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset;
        rst_n      = 1'b0;
        req_valid  = '0; req_a  = '0; req_b  = '0; rsp_ready  = 1'b0;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Observe responses; optionally a requester drops valid once accepted.
    task automatic collect(input int n, input bit drop);
        logic [N-1:0] acc;
        int cyc;
        acc = '0;
        cyc = 0;
        got_id.delete();
        got_p.delete();
        while (got_id.size() < n && cyc < 100) begin
            #1;
            if (busy) chk("ready_low_busy", 32'(req_ready), 0);
            acc = req_ready & req_valid;
            if (rsp_valid && rsp_ready) begin
                got_id.push_back(int'(rsp_id));
                got_p.push_back(int'(rsp_p));
            end
            @(negedge clk);
            cyc++;
            if (drop) req_valid = req_valid & ~acc;
        end
        if (got_id.size() < n) chk("collect_timeout", 32'(got_id.size()), 32'(n));
    endtask

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] rdy;
        logic [7:0] p;
    } vec_t;

    task automatic table_test;
        vec_t tbl[7];
        int   i;
        tbl[0] = '{0, 4'd7,  4'd5,  4'b0001, 8'd35};
        tbl[1] = '{1, 4'd1,  4'd0,  4'b0010, 8'd0};
        tbl[2] = '{2, 4'd15, 4'd15, 4'b0100, 8'd225};
        tbl[3] = '{3, 4'd8,  4'd9,  4'b1000, 8'd72};
        tbl[4] = '{0, 4'd15, 4'd1,  4'b0001, 8'd15};
        tbl[5] = '{1, 4'd0,  4'd0,  4'b0010, 8'd0};
        tbl[6] = '{3, 4'd12, 4'd11, 4'b1000, 8'd132};
        for (int v = 0; v < 7; v++) begin
            i = tbl[v].idx;
            req_valid    = '0;
            req_valid[i] = 1'b1;
            req_a[i*W +: W] = tbl[v].a;
            req_b[i*W +: W] = tbl[v].b;
            #1 chk("tbl_ready", 32'(req_ready), 32'(tbl[v].rdy));
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("tbl_busy", 32'(busy), 1);
            chk("tbl_early_valid", 32'(rsp_valid), 0);
            chk("tbl_mul_a", 32'(mul_a), 32'(tbl[v].a));
            chk("tbl_mul_b", 32'(mul_b), 32'(tbl[v].b));
            chk("tbl_ready_mul", 32'(req_ready), 0);
            @(negedge clk);
            #1;
            chk("tbl_rsp_valid", 32'(rsp_valid), 1);
            chk("tbl_rsp_id", 32'(rsp_id), 32'(i));
            chk("tbl_rsp_p", 32'(rsp_p), 32'(tbl[v].p));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            chk("tbl_rsp_clear", 32'(rsp_valid), 0);
            chk("tbl_done_cnt", 32'(done_cnt), 32'(v + 1));
            chk("tbl_idle", 32'(busy), 0);
        end
    endtask

    task automatic simultaneous_test;
        do_reset;
        req_valid = 4'b0101;
        req_a[0 +: 4] = 4'd8;  req_b[0 +: 4] = 4'd9;
        req_a[8 +: 4] = 4'd15; req_b[8 +: 4] = 4'd15;
        rsp_ready = 1'b1;
        #1 chk("sim_first_grant", 32'(req_ready), 32'h1);
        collect(2, 1'b1);
        if (got_id.size() == 2) begin
            chk("sim_id0", 32'(got_id[0]), 0);
            chk("sim_p0",  32'(got_p[0]), 72);
            chk("sim_id1", 32'(got_id[1]), 2);
            chk("sim_p1",  32'(got_p[1]), 225);
        end
        rsp_ready = 1'b0;
        req_valid = '0;
    endtask

    task automatic rr_test;
        int exp_id[5];
        int exp_p[5];
        exp_id = '{0, 1, 2, 3, 0};
        exp_p  = '{3, 6, 9, 12, 3};
        do_reset;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 4'(i + 1);
            req_b[i*W +: W] = 4'd3;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        collect(5, 1'b0);
        if (got_id.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("rr_id", 32'(got_id[k]), 32'(exp_id[k]));
                chk("rr_p",  32'(got_p[k]),  32'(exp_p[k]));
            end
        end
        rsp_ready = 1'b0;
        req_valid = '0;
    endtask

    task automatic backpressure_test;
        do_reset;
        req_valid = 4'b0010;
        req_a[4 +: 4] = 4'd1; req_b[4 +: 4] = 4'd0;
        rsp_ready = 1'b0;
        #1 chk("bp_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b1000;
        req_a[12 +: 4] = 4'd5; req_b[12 +: 4] = 4'd5;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id", 32'(rsp_id), 1);
            chk("bp_p", 32'(rsp_p), 0);
            chk("bp_no_grant", 32'(req_ready), 0);
            chk("bp_busy", 32'(busy), 1);
            chk("bp_mul_a_hold", 32'(mul_a), 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp_released", 32'(rsp_valid), 0);
        chk("bp_done", 32'(done_cnt), 1);
        chk("bp_next_grant", 32'(req_ready), 32'h8);
        req_valid = '0;
    endtask

    task automatic midreset_test;
        do_reset;
        req_valid = 4'b0100;
        req_a[8 +: 4] = 4'd3; req_b[8 +: 4] = 4'd3;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("mr_done1", 32'(done_cnt), 1);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[4 +: 4] = 4'd15; req_b[4 +: 4] = 4'd15;
        #1 chk("mr_grant1", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b0001;
        #1 chk("mr_in_mul", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_rsp_valid", 32'(rsp_valid), 0);
        chk("mr_mul_a", 32'(mul_a), 0);
        chk("mr_mul_b", 32'(mul_b), 0);
        chk("mr_rsp_p", 32'(rsp_p), 0);
        chk("mr_rsp_id", 32'(rsp_id), 0);
        chk("mr_done", 32'(done_cnt), 0);
        chk("mr_ready_in_reset", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("mr_ptr_zero", 32'(req_ready), 32'h1);
        chk("mr_post_valid", 32'(rsp_valid), 0);
        chk("mr_post_done", 32'(done_cnt), 0);
        req_valid = '0;
    endtask

    task automatic settle3_test;
        int         idx[2];
        logic [3:0] a[2];
        logic [3:0] b[2];
        int         p[2];
        idx = '{0, 3}; a = '{4'd7, 4'd6}; b = '{4'd5, 4'd7}; p = '{35, 42};
        do_reset;
        for (int t = 0; t < 2; t++) begin
            req_valid3 = '0;
            req_valid3[idx[t]] = 1'b1;
            req_a3[idx[t]*W +: W] = a[t];
            req_b3[idx[t]*W +: W] = b[t];
            #1 chk("s3_ready", 32'(req_ready3), 32'(1) << idx[t]);
            // Counting the accept edge as the first, the response shows
            // after the fourth edge.
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                req_valid3 = '0;
                #1;
                if (k < 4) begin
                    chk("s3_not_yet", 32'(rsp_valid3), 0);
                    chk("s3_busy", 32'(busy3), 1);
                end else begin
                    chk("s3_valid", 32'(rsp_valid3), 1);
                    chk("s3_p", 32'(rsp_p3), 32'(p[t]));
                    chk("s3_id", 32'(rsp_id3), 32'(idx[t]));
                end
            end
            rsp_ready3 = 1'b1;
            @(negedge clk);
            rsp_ready3 = 1'b0;
            #1;
            chk("s3_clear", 32'(rsp_valid3), 0);
            chk("s3_done", 32'(done_cnt3), 32'(t + 1));
        end
    endtask

    // Reference: one transaction at a time, described by "edges left until
    // the product is presented", a pending-response flag and a search origin.
    task automatic random_test;
        int         m_left, m_ptr, m_id, m_rid, m_rp, m_done, g, i;
        int         m_a, m_b;
        bit         m_resp, idle;
        logic [3:0] exp_rdy;
        m_left = 0; m_ptr = 0; m_id = 0; m_rid = 0; m_rp = 0; m_done = 0;
        m_a = 0; m_b = 0; m_resp = 1'b0;
        do_reset;
        for (int c = 0; c < 2500; c++) begin
            req_valid = 4'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            idle = (m_left == 0) && !m_resp;
            g = -1;
            if (idle) begin
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr + k) % N;
                    if (g < 0 && req_valid[i]) g = i;
                end
            end
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
            chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rnd_busy", 32'(busy), 32'(!idle));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_resp));
            chk("rnd_rsp_id", 32'(rsp_id), 32'(m_rid));
            chk("rnd_rsp_p", 32'(rsp_p), 32'(m_rp));
            chk("rnd_done_cnt", 32'(done_cnt), 32'(m_done % 256));
            chk("rnd_mul_a", 32'(mul_a), 32'(m_a));
            chk("rnd_mul_b", 32'(mul_b), 32'(m_b));
            if (g >= 0) begin
                m_a = int'(req_a[g*W +: W]);
                m_b = int'(req_b[g*W +: W]);
                m_id = g;
                m_left = 1;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_resp = 1'b1;
                    m_rid  = m_id;
                    m_rp   = m_a * m_b;
                end
            end else if (m_resp && rsp_ready) begin
                m_resp = 1'b0;
                m_done++;
                m_ptr = (m_id + 1) % N;
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        do_reset;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_p", 32'(rsp_p), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_b", 32'(mul_b), 0);
        chk("rst_done", 32'(done_cnt), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst3_done", 32'(done_cnt3), 0);
        table_test;
        simultaneous_test;
        rr_test;
        backpressure_test;
        midreset_test;
        settle3_test;
        random_test;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
